// File: rtl/bridge_sequencer.sv
// Drawbridge actuator sequencer: warn, close barrier, wait deck clear, raise, hold, lower, reopen.
// Latency: inputs sampled on a rising edge affect state and outputs right after that edge; outputs are Moore.
// No backpressure: the sequencer reacts every cycle. Optional clear timeout guarded by BRIDGE_SEQ_TIMEOUT_EN.
module bridge_sequencer #(
    parameter int WARN_CYCLES   = 8,
    parameter int MOVE_CYCLES   = 16,
    parameter int MIN_UP_CYCLES = 4,
    parameter int CLEAR_TIMEOUT = 64,
    parameter int CW            = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_raiseReq,
    input  logic       i_carPresent,
    input  logic       i_boatHere,
    output logic       o_barrierDown,
    output logic       o_alert,
    output logic       o_bridgeUp,
    output logic       o_moving,
    output logic       o_fault,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WARN  = 3'd1,
        S_CLEAR = 3'd2,
        S_RAISE = 3'd3,
        S_UP    = 3'd4,
        S_LOWER = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    // Timer values on which a state's final cycle is recognised (timer starts at 0 on entry).
    localparam logic [CW-1:0] WARN_LAST   = CW'(WARN_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LAST   = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] MIN_UP_LAST = CW'(MIN_UP_CYCLES - 1);
`ifdef BRIDGE_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_TIMEOUT - 1);
`endif

    // Reject parameter sets the timer cannot represent.
    if (WARN_CYCLES < 1 || MOVE_CYCLES < 1 || MIN_UP_CYCLES < 1 || CLEAR_TIMEOUT < 1 ||
        WARN_CYCLES > 2**CW || MOVE_CYCLES > 2**CW || MIN_UP_CYCLES > 2**CW ||
        CLEAR_TIMEOUT > 2**CW) begin : g_badParams
        $error("bridge_sequencer: cycle parameters must be in 1..2**CW");
    end

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] t;
    logic          timing;

    // Timer runs only in the timed states; IDLE and FAULT hold it at its entry value.
    assign timing = (state == S_WARN) || (state == S_CLEAR) || (state == S_RAISE) ||
                    (state == S_UP)   || (state == S_LOWER);

    // State register and per-state timer (cleared on every state change, saturating).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            t     <= '0;
        end else begin
            state <= nextState;
            if (nextState != state) begin
                t <= '0;
            end else if (timing && (t != '1)) begin
                t <= t + 1'b1;
            end
        end
    end

    // Next-state logic; within each state the checks are in priority order.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: begin
                if (i_raiseReq) nextState = S_WARN;
            end
            S_WARN: begin
                if (!i_raiseReq)          nextState = S_IDLE;
                else if (t == WARN_LAST)  nextState = S_CLEAR;
            end
            S_CLEAR: begin
                // Abort beats deck-clear so the barrier reopens rather than raising.
                if (!i_raiseReq)          nextState = S_IDLE;
                else if (!i_carPresent)   nextState = S_RAISE;
`ifdef BRIDGE_SEQ_TIMEOUT_EN
                else if (t == CLEAR_LAST) nextState = S_FAULT;
`endif
            end
            S_RAISE: begin
                if (t == MOVE_LAST) nextState = S_UP;
            end
            S_UP: begin
                // A boat under the span keeps the bridge up even once the request drops.
                if ((t >= MIN_UP_LAST) && !i_raiseReq && !i_boatHere) nextState = S_LOWER;
            end
            S_LOWER: begin
                if (t == MOVE_LAST) nextState = S_IDLE;
            end
            S_FAULT: begin
                nextState = S_FAULT;
            end
            default: begin
                nextState = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        o_barrierDown = 1'b0;
        o_alert       = 1'b0;
        o_bridgeUp    = 1'b0;
        o_moving      = 1'b0;
        case (state)
            S_WARN: begin
                o_alert = 1'b1;
            end
            S_CLEAR, S_FAULT: begin
                o_barrierDown = 1'b1;
                o_alert       = 1'b1;
            end
            S_RAISE, S_LOWER: begin
                o_barrierDown = 1'b1;
                o_alert       = 1'b1;
                o_moving      = 1'b1;
            end
            S_UP: begin
                o_barrierDown = 1'b1;
                o_alert       = 1'b1;
                o_bridgeUp    = 1'b1;
            end
            default: begin
                o_barrierDown = 1'b0;
            end
        endcase
    end

`ifdef BRIDGE_SEQ_TIMEOUT_EN
    assign o_fault = (state == S_FAULT);
`else
    assign o_fault = 1'b0;
`endif

    assign o_state = state;

endmodule

// File: tb/tb_bridge_sequencer.sv
module tb_bridge_sequencer;

    localparam int WARN_CYCLES   = 8;
    localparam int MOVE_CYCLES   = 16;
    localparam int MIN_UP_CYCLES = 4;
    localparam int CLEAR_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       raiseReq;
    logic       carPresent;
    logic       boatHere;
    logic       barrierDown;
    logic       alert;
    logic       bridgeUp;
    logic       moving;
    logic       fault;
    logic [2:0] stateCode;

    int total = 0;
    int bad   = 0;
    int cycleNo = 0;

    logic [7:0] expQ[$];

    bridge_sequencer #(
        .WARN_CYCLES  (WARN_CYCLES),
        .MOVE_CYCLES  (MOVE_CYCLES),
        .MIN_UP_CYCLES(MIN_UP_CYCLES),
        .CLEAR_TIMEOUT(CLEAR_TIMEOUT),
        .CW           (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_raiseReq   (raiseReq),
        .i_carPresent (carPresent),
        .i_boatHere   (boatHere),
        .o_barrierDown(barrierDown),
        .o_alert      (alert),
        .o_bridgeUp   (bridgeUp),
        .o_moving     (moving),
        .o_fault      (fault),
        .o_state      (stateCode)
    );

    always #5 clk = ~clk;

    // Reference model: the current phase and how many cycles it has been occupied (1 on entry).
    localparam int IDLE = 0, WARN = 1, CLEAR = 2, RAISE = 3, UP = 4, LOWER = 5, FAULT = 6;
    int phase = IDLE;
    int occupied = 1;

    // Outputs barrierDown/alert/bridgeUp/moving/fault per phase.
    function automatic logic [4:0] phaseOutputs(input int p);
        case (p)
            WARN:    return 5'b01000;
            CLEAR:   return 5'b11000;
            RAISE:   return 5'b11010;
            UP:      return 5'b11100;
            LOWER:   return 5'b11010;
            FAULT:   return 5'b11001;
            default: return 5'b00000;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs held during that edge.
    task automatic modelStep();
        int nx;
        nx = phase;
        if (rst) begin
            nx = IDLE;
            occupied = 0;
            phase = IDLE;
        end else begin
            case (phase)
                IDLE:  if (raiseReq) nx = WARN;
                WARN:  if (!raiseReq) nx = IDLE;
                       else if (occupied == WARN_CYCLES) nx = CLEAR;
                CLEAR: if (!raiseReq) nx = IDLE;
                       else if (!carPresent) nx = RAISE;
`ifdef BRIDGE_SEQ_TIMEOUT_EN
                       else if (occupied == CLEAR_TIMEOUT) nx = FAULT;
`endif
                RAISE: if (occupied == MOVE_CYCLES) nx = UP;
                UP:    if (occupied >= MIN_UP_CYCLES && !raiseReq && !boatHere) nx = LOWER;
                LOWER: if (occupied == MOVE_CYCLES) nx = IDLE;
                default: nx = phase;
            endcase
        end
        if (nx != phase || rst) occupied = 1;
        else occupied = occupied + 1;
        phase = nx;
        expQ.push_back({phase[2:0], phaseOutputs(phase)});
    endtask

    // Hold the given inputs for n clock edges, recording the expected response to each edge.
    task automatic cyc(input logic r, input logic c, input logic b, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            raiseReq   = r;
            carPresent = c;
            boatHere   = b;
            rst        = rs;
            @(posedge clk);
            modelStep();
            #1;
        end
    endtask

    // Monitor: every cycle after an edge the DUT presents a state; compare it with the scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp;
        logic [7:0] act;
        cycleNo <= cycleNo + 1;
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            act = {stateCode, barrierDown, alert, bridgeUp, moving, fault};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL seq_check cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                         cycleNo, act[7:5], act[4:0], exp[7:5], exp[4:0]);
            end
        end
    end

    initial begin
        logic r, c, b, rs;
        // Reset then idle.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 20);
        // Nominal cycle, empty deck.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 40);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 30);
        // Cars on deck hold CLEAR, then release.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 30);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 30);
        // Boat hold in UP, then lower.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 25);
        // Abort in WARN at t=3.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);
        // Simultaneous abort and deck clear in CLEAR.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);
        // Request reasserted during LOWER is serviced from IDLE afterwards.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 35);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 40);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 20);
        // Long boat hold past timer saturation.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 30);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 300);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 20);
        // Reset in the middle of a raise.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 15);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);
`ifdef BRIDGE_SEQ_TIMEOUT_EN
        // Stuck car leads to a sticky fault.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 90);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5);
`endif
        // Random segments with occasional per-cycle sensor flips and rare resets.
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            r   = 1'($urandom_range(0, 3) != 0);
            c   = 1'($urandom_range(0, 2) == 0);
            b   = 1'($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) c = ~c;
                if ($urandom_range(0, 9) == 0) b = ~b;
                rs = 1'($urandom_range(0, 199) == 0);
                cyc(r, c, b, rs, 1);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
